// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one word-wide memory port between ICache refill,
// DCache refill and DCache write-back. Lines are moved as four word beats.
// A one-entry write buffer absorbs a DCache write-back at any time; it is
// drained before any new read is started.
// Optional feature: define ARB_RR_EN for round-robin IC/DC read arbitration;
// without it the DCache read always wins.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ic_rd_req_i,
  input  logic [ADDR_W-1:0]   ic_rd_addr_i,
  output logic                ic_rd_rdy_o,
  output logic [DATA_W-1:0]   ic_rd_data_o,
  output logic                ic_rd_valid_o,
  output logic [2:0]          ic_rd_num_o,
  input  logic                dc_rd_req_i,
  input  logic [ADDR_W-1:0]   dc_rd_addr_i,
  output logic                dc_rd_rdy_o,
  output logic [DATA_W-1:0]   dc_rd_data_o,
  output logic                dc_rd_valid_o,
  output logic [2:0]          dc_rd_num_o,
  input  logic                dc_wr_req_i,
  input  logic [ADDR_W-1:0]   dc_wr_addr_i,
  input  logic [4*DATA_W-1:0] dc_wr_data_i,
  output logic                dc_wr_rdy_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_WAIT} state_e;

  state_e                state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic                  owner_q, owner_d;   // 0 = IC, 1 = DC
  logic [ADDR_W-5:0]     rd_line_q, rd_line_d;
  logic [ADDR_W-5:0]     wb_line_q, wb_line_d;
  logic [4*DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                  full_q, full_d;
  logic                  wr_acc;
  logic                  rd_grant;
  logic                  dc_wins;

  // Line offsets are regenerated from the beat counter, so the low address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_rd_addr_i[3:0], dc_rd_addr_i[3:0], dc_wr_addr_i[3:0]};

  assign wr_acc      = dc_wr_req_i & ~full_q;
  assign dc_wr_rdy_o = ~full_q;
  assign ic_rd_rdy_o = rd_grant & ~dc_wins;
  assign dc_rd_rdy_o = rd_grant &  dc_wins;

`ifdef ARB_RR_EN
  logic rr_q, rr_d;   // owner of the most recent read grant; reset = IC last
  assign dc_wins = dc_rd_req_i & (~ic_rd_req_i | ~rr_q);
  assign rr_d    = rd_grant ? dc_wins : rr_q;

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
`else
  assign dc_wins = dc_rd_req_i;
`endif

  // State, beat counter, read context and write buffer registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      owner_q   <= 1'b0;
      rd_line_q <= '0;
      wb_line_q <= '0;
      wb_data_q <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      owner_q   <= owner_d;
      rd_line_q <= rd_line_d;
      wb_line_q <= wb_line_d;
      wb_data_q <= wb_data_d;
      full_q    <= full_d;
    end

  // Next state, buffer load, read routing and memory beat drive.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    owner_d       = owner_q;
    rd_line_d     = rd_line_q;
    wb_line_d     = wb_line_q;
    wb_data_d     = wb_data_q;
    full_d        = full_q;
    rd_grant      = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    ic_rd_valid_o = 1'b0;
    ic_rd_data_o  = '0;
    ic_rd_num_o   = 3'd0;
    dc_rd_valid_o = 1'b0;
    dc_rd_data_o  = '0;
    dc_rd_num_o   = 3'd0;

    // The buffer can load in any state; it only ever holds one line.
    if (wr_acc) begin
      full_d    = 1'b1;
      wb_line_d = dc_wr_addr_i[ADDR_W-1:4];
      wb_data_d = dc_wr_data_i;
    end

    case (state_q)
      IDLE: begin
        if (full_q || wr_acc) begin
          // Pending or just-accepted write always drains before a read starts.
          state_d = WR;
          beat_d  = 2'd0;
        end else if (rst_n && (ic_rd_req_i || dc_rd_req_i)) begin
          rd_grant  = 1'b1;
          owner_d   = dc_wins;
          rd_line_d = dc_wins ? dc_rd_addr_i[ADDR_W-1:4] : ic_rd_addr_i[ADDR_W-1:4];
          state_d   = RD_REQ;
          beat_d    = 2'd0;
        end
      end
      WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {wb_line_q, beat_q, 2'b00};
        mem_wdata_o = wb_data_q[DATA_W*beat_q +: DATA_W];
        if (mem_gnt_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            full_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {rd_line_q, beat_q, 2'b00};
        if (mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (owner_q) begin
            dc_rd_valid_o = 1'b1;
            dc_rd_data_o  = mem_rdata_i;
            dc_rd_num_o   = {1'b0, beat_q} + 3'd1;
          end else begin
            ic_rd_valid_o = 1'b1;
            ic_rd_data_o  = mem_rdata_i;
            ic_rd_num_o   = {1'b0, beat_q} + 3'd1;
          end
          if (beat_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus pushes expected memory
// beats and read responses; a negedge monitor pops and compares them.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ic_rd_req_i = 1'b0;
  logic [AW-1:0]   ic_rd_addr_i = '0;
  logic            ic_rd_rdy_o, ic_rd_valid_o;
  logic [DW-1:0]   ic_rd_data_o;
  logic [2:0]      ic_rd_num_o;
  logic            dc_rd_req_i = 1'b0;
  logic [AW-1:0]   dc_rd_addr_i = '0;
  logic            dc_rd_rdy_o, dc_rd_valid_o;
  logic [DW-1:0]   dc_rd_data_o;
  logic [2:0]      dc_rd_num_o;
  logic            dc_wr_req_i = 1'b0;
  logic [AW-1:0]   dc_wr_addr_i = '0;
  logic [4*DW-1:0] dc_wr_data_i = '0;
  logic            dc_wr_rdy_o;
  logic            mem_req_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_gnt_i = 1'b0;
  logic            mem_rvalid_i = 1'b0;
  logic [DW-1:0]   mem_rdata_i = '0;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_rd_req_i(ic_rd_req_i), .ic_rd_addr_i(ic_rd_addr_i), .ic_rd_rdy_o(ic_rd_rdy_o),
    .ic_rd_data_o(ic_rd_data_o), .ic_rd_valid_o(ic_rd_valid_o), .ic_rd_num_o(ic_rd_num_o),
    .dc_rd_req_i(dc_rd_req_i), .dc_rd_addr_i(dc_rd_addr_i), .dc_rd_rdy_o(dc_rd_rdy_o),
    .dc_rd_data_o(dc_rd_data_o), .dc_rd_valid_o(dc_rd_valid_o), .dc_rd_num_o(dc_rd_num_o),
    .dc_wr_req_i(dc_wr_req_i), .dc_wr_addr_i(dc_wr_addr_i), .dc_wr_data_i(dc_wr_data_i),
    .dc_wr_rdy_o(dc_wr_rdy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct packed { logic dc; logic [2:0] num; logic [31:0] data; } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int    n_tot = 0;
  int    n_bad = 0;
  int    first_cyc = 0;
  int    last_cyc = 0;

  // memory model knobs
  logic [31:0] mem_base = '0;
  int          gnt_wait = 0;
  int          wcnt = 0;
  logic        rv_pend = 1'b0;
  logic [31:0] rv_data = '0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_rd(input logic [31:0] addr, input logic dc, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      beat_q.push_back('{we: 1'b0, addr: {addr[31:4], 4'h0} + 32'(4*k), wdata: 32'h0});
      rsp_q.push_back('{dc: dc, num: 3'(k+1), data: base + 32'(k)});
    end
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [127:0] line);
    for (int k = 0; k < 4; k++)
      beat_q.push_back('{we: 1'b1, addr: {addr[31:4], 4'h0} + 32'(4*k), wdata: line[32*k +: 32]});
  endtask

  function automatic logic [127:0] mkline(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic logic [159:0] outs();
    return 160'({ic_rd_rdy_o, ic_rd_valid_o, ic_rd_num_o, ic_rd_data_o,
                 dc_rd_rdy_o, dc_rd_valid_o, dc_rd_num_o, dc_rd_data_o,
                 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dc_wr_rdy_o});
  endfunction

  task automatic drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (beat_q.size() == 0 && rsp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, {beat_q.size(), rsp_q.size()}, 0);
    tick();
  endtask

  // Memory model: grants after gnt_wait idle request cycles, returns read data one cycle after gnt.
  initial forever begin
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_gnt_i    = 1'b0;
    if (!rst_n) begin
      rv_pend = 1'b0;
      wcnt    = 0;
    end else begin
      if (rv_pend) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rv_data;
        rv_pend      = 1'b0;
      end
      if (mem_req_o) begin
        if (wcnt >= gnt_wait) begin
          mem_gnt_i = 1'b1;
          wcnt      = 0;
          if (!mem_we_o) begin
            rv_pend = 1'b1;
            rv_data = mem_base + 32'(mem_addr_o[3:2]);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and every read response.
  beat_t mb;
  rsp_t  mr;
  logic  hold_prev = 1'b0;
  logic [64:0] prev_beat = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_o && hold_prev)
        chk("hold_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, prev_beat);
      hold_prev = mem_req_o && !mem_gnt_i;
      prev_beat = {mem_we_o, mem_addr_o, mem_wdata_o};
      if (mem_req_o && mem_gnt_i) begin
        if (beat_q.size() == 0) begin
          n_tot++; n_bad++;
          $display("FAIL unexpected_beat: got addr %0h we %0b want none", mem_addr_o, mem_we_o);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_we", mem_we_o, mb.we);
          chk("beat_addr", mem_addr_o, mb.addr);
          if (mb.we) chk("beat_wdata", mem_wdata_o, mb.wdata);
        end
      end
      if (ic_rd_valid_o && dc_rd_valid_o) begin
        n_tot++; n_bad++;
        $display("FAIL both_valid: got ic=1 dc=1 want one");
      end else if (ic_rd_valid_o || dc_rd_valid_o) begin
        if (rsp_q.size() == 0) begin
          n_tot++; n_bad++;
          $display("FAIL unexpected_valid: got dc=%0b num=%0d want none", dc_rd_valid_o, dc_rd_valid_o ? dc_rd_num_o : ic_rd_num_o);
        end else begin
          mr = rsp_q.pop_front();
          if (dc_rd_valid_o) chk("rsp", {1'b1, dc_rd_num_o, dc_rd_data_o}, mr);
          else               chk("rsp", {1'b0, ic_rd_num_o, ic_rd_data_o}, mr);
          if (mr.num == 3'd1) first_cyc = cyc;
          if (mr.num == 3'd4) last_cyc = cyc;
        end
      end
      if (!ic_rd_valid_o) chk("ic_num_idle", ic_rd_num_o, 0);
      if (!dc_rd_valid_o) chk("dc_num_idle", dc_rd_num_o, 0);
    end else begin
      hold_prev = 1'b0;
    end
  end

  int g, t0;
  logic [2:0] exp_dc;

  initial begin
    // reset values
    #1 rst_n = 1'b0;
    #1 chk("reset_outs", outs(), 160'd1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // T1: IC read 0x1234, zero-wait memory
    mem_base = 32'hA0;
    push_rd(32'h1234, 1'b0, 32'hA0, 4);
    ic_rd_req_i = 1'b1; ic_rd_addr_i = 32'h0000_1234;
    @(negedge clk);
    chk("t1_rdy", {ic_rd_rdy_o, dc_rd_rdy_o}, 2'b10);
    g = cyc;
    tick(); ic_rd_req_i = 1'b0;
    drain("t1_drain");
    chk("t1_first_lat", first_cyc - g, 2);
    chk("t1_last_lat", last_cyc - g, 8);

    // T3: IC and DC held together for three bursts
`ifdef ARB_RR_EN
    exp_dc = 3'b101;
`else
    exp_dc = 3'b111;
`endif
    mem_base = 32'hC0;
    for (int k = 0; k < 3; k++)
      push_rd(exp_dc[k] ? 32'h5000 : 32'h4000, exp_dc[k], 32'hC0, 4);
    ic_rd_req_i = 1'b1; ic_rd_addr_i = 32'h4000;
    dc_rd_req_i = 1'b1; dc_rd_addr_i = 32'h5000;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ic_rd_rdy_o || dc_rd_rdy_o) break;
      end
      chk("t3_grant", {ic_rd_rdy_o, dc_rd_rdy_o}, exp_dc[k] ? 2'b01 : 2'b10);
    end
    tick(); ic_rd_req_i = 1'b0; dc_rd_req_i = 1'b0;
    drain("t3_drain");

    // T2: write-back 0x2000 and DC read 0x3000 in the same cycle
    mem_base = 32'hB0;
    push_wr(32'h2000, mkline(32'hD0));
    push_rd(32'h3000, 1'b1, 32'hB0, 4);
    dc_wr_req_i = 1'b1; dc_wr_addr_i = 32'h2000; dc_wr_data_i = mkline(32'hD0);
    dc_rd_req_i = 1'b1; dc_rd_addr_i = 32'h3000;
    @(negedge clk);
    chk("t2_accept", {dc_wr_rdy_o, dc_rd_rdy_o}, 2'b10);
    tick(); dc_wr_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_busy", {dc_wr_rdy_o, dc_rd_rdy_o}, 2'b00);
    end
    @(negedge clk);
    chk("t2_free", {dc_wr_rdy_o, dc_rd_rdy_o}, 2'b11);
    tick(); dc_rd_req_i = 1'b0;
    drain("t2_drain");

    // T4: write with gnt delayed 3 cycles per beat
    gnt_wait = 3;
    push_wr(32'h6004, mkline(32'hE0));
    dc_wr_req_i = 1'b1; dc_wr_addr_i = 32'h6004; dc_wr_data_i = mkline(32'hE0);
    @(negedge clk);
    chk("t4_accept", dc_wr_rdy_o, 1'b1);
    t0 = cyc;
    tick(); dc_wr_req_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dc_wr_rdy_o) break;
    end
    chk("t4_drain_cycles", cyc - t0, 17);
    gnt_wait = 0;
    drain("t4_drain");

    // T5: write accepted during an IC burst after beat 2
    mem_base = 32'hF0;
    push_rd(32'h7000, 1'b0, 32'hF0, 4);
    ic_rd_req_i = 1'b1; ic_rd_addr_i = 32'h7000;
    @(negedge clk);
    chk("t5_ic_rdy", ic_rd_rdy_o, 1'b1);
    g = cyc;
    tick(); ic_rd_req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ic_rd_valid_o && ic_rd_num_o == 3'd2) break;
    end
    tick();
    push_wr(32'h8000, mkline(32'h80));
    push_rd(32'h9000, 1'b1, 32'hF0, 4);
    dc_wr_req_i = 1'b1; dc_wr_addr_i = 32'h8000; dc_wr_data_i = mkline(32'h80);
    dc_rd_req_i = 1'b1; dc_rd_addr_i = 32'h9000;
    @(negedge clk);
    chk("t5_accept", {dc_wr_rdy_o, dc_rd_rdy_o}, 2'b10);
    tick(); dc_wr_req_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dc_rd_rdy_o) break;
    end
    chk("t5_grant_cyc", cyc - g, 14);
    chk("t5_grant_empty", dc_wr_rdy_o, 1'b1);
    tick(); dc_rd_req_i = 1'b0;
    drain("t5_drain");

    // T6: reset in RD_WAIT after beat 2
    mem_base = 32'h10;
    push_rd(32'hA000, 1'b1, 32'h10, 2);
    dc_rd_req_i = 1'b1; dc_rd_addr_i = 32'hA000;
    @(negedge clk);
    chk("t6_dc_rdy", dc_rd_rdy_o, 1'b1);
    tick(); dc_rd_req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dc_rd_valid_o && dc_rd_num_o == 3'd2) break;
    end
    #1 rst_n = 1'b0;
    #1 chk("t6_reset_outs", outs(), 160'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_valid", {ic_rd_valid_o, dc_rd_valid_o, mem_req_o}, 3'b000);
    end
    chk("t6_sb_empty", {beat_q.size(), rsp_q.size()}, 0);
    tick();
    mem_base = 32'h20;
    push_rd(32'hB000, 1'b0, 32'h20, 4);
    ic_rd_req_i = 1'b1; ic_rd_addr_i = 32'hB000;
    @(negedge clk);
    chk("t6_ic_rdy", ic_rd_rdy_o, 1'b1);
    tick(); ic_rd_req_i = 1'b0;
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
